// File: rtl/scan_pkg.sv
// Shared constants and helpers for the 4x4 key matrix scan path.
package scan_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_KEYS = 16;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned ROW_W    = 2;
  localparam int unsigned KEY_W    = 4;

  // Key index = col*4 + row; with four rows this is the plain concatenation.
  function automatic logic [KEY_W-1:0] key_idx(input logic [COL_W-1:0] col,
                                               input logic [ROW_W-1:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key frame-rate debouncer: flips the debounced level after
// DEBOUNCE_SCANS consecutive differing samples; flags 0->1 flips.
module key_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic sample,
  output logic state,
  output logic press_pulse
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_flip;

  assign w_differ    = sample_en && (sample != r_state);
  assign w_flip      = w_differ && (r_cnt == CNT_LAST);
  assign press_pulse = w_flip && !r_state;
  assign state       = r_state;

  // Debounce counter and debounced level, updated only at this key's sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else if (sample_en) begin
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_state <= ~r_state;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// 4x4 active-low key matrix scanner: column strobe, row synchronizer,
// per-key debounce and a lowest-index-first press event queue.
module key_matrix_scanner
  import scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 3,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clk_scan,
  input  logic                rst_n,
  output logic [NUM_COLS-1:0] col_n,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [COL_W-1:0]    scan_col,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                key_valid,
  output logic [KEY_W-1:0]    key_code,
  input  logic                key_ready
);

  localparam int unsigned PH_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SETTLE_CYCLES);

  logic [PH_W-1:0]     r_phase;
  logic [COL_W-1:0]    r_scan_col;
  logic [NUM_COLS-1:0] r_col_n;
  logic [NUM_ROWS-1:0] r_row_s1;
  logic [NUM_ROWS-1:0] r_row_s2;
  logic [NUM_KEYS-1:0] r_pending;

  logic                w_sample_edge;
  logic [COL_W-1:0]    w_col_next;
  logic [NUM_ROWS-1:0] w_rows;
  logic [NUM_KEYS-1:0] w_key_state;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_clear;
  logic [KEY_W-1:0]    w_code;
  logic                w_valid;

  assign w_sample_edge = (r_phase == PH_LAST);
  assign w_col_next    = r_scan_col + COL_W'(1);
  assign w_rows        = ~r_row_s2;

  // Phase counter and column driver; column advances on the sample edge.
  always_ff @(posedge clk_scan or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= '0;
      r_scan_col <= '0;
      r_col_n    <= 4'b1110;
    end else if (w_sample_edge) begin
      r_phase    <= '0;
      r_scan_col <= w_col_next;
      r_col_n    <= ~(NUM_COLS'(1) << w_col_next);
    end else begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

  // Two-flop synchronizer on the asynchronous row returns (idle high).
  always_ff @(posedge clk_scan or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
    end else begin
      r_row_s1 <= row_n;
      r_row_s2 <= r_row_s1;
    end
  end

  // One debouncer per key; only the driven column's keys see a sample edge.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      localparam int unsigned K = 32'(key_idx(COL_W'(c), ROW_W'(r)));
      key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_deb (
        .clk        (clk_scan),
        .rst_n      (rst_n),
        .sample_en  (w_sample_edge && (r_scan_col == COL_W'(c))),
        .sample     (w_rows[r]),
        .state      (w_key_state[K]),
        .press_pulse(w_press[K])
      );
    end
  end

  // Lowest-set-bit priority encoder over the pending mask.
  always_comb begin
    w_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (r_pending[i]) w_code = KEY_W'(i);
    end
  end

  assign w_valid = |r_pending;
  assign w_clear = (w_valid && key_ready) ? (NUM_KEYS'(1) << w_code) : '0;

  // Pending press mask: a new press wins over a same-edge acceptance.
  always_ff @(posedge clk_scan or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_press;
    end
  end

  assign col_n     = r_col_n;
  assign scan_col  = r_scan_col;
  assign key_state = w_key_state;
  assign key_valid = w_valid;
  assign key_code  = w_code;

endmodule

// File: doc/key_matrix_scanner.md
# key_matrix_scanner

Scans a 4×4 active-low key/button matrix by strobing one column at a time and sampling the rows, in the same four-step round-robin the display scan uses. Each of the 16 keys is debounced over whole scan frames. Debounced state and a queue of press events (valid/ready) go to the game-control logic. The block is the input-side counterpart of the display scan path and runs on the scan clock.

## Interface

**Parameters**
- `SETTLE_CYCLES`, default 3: cycles each column is driven before its rows are sampled. Must be ≥ 2 to cover the row synchronizer.
- `DEBOUNCE_SCANS`, default 4: consecutive frames a key sample must differ from the debounced state before that state flips. Range 1..15.

**Ports**
- `clk_scan`, input, 1: scan clock; all logic is on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `col_n`, output, 4: column strobes, one-hot, active-low.
- `row_n`, input, 4: row returns, active-low, asynchronous (pulled up off-chip).
- `scan_col`, output, 2: index of the currently driven column.
- `key_state`, output, 16: debounced key levels, 1 = pressed. Key index k = col·4 + row.
- `key_valid`, output, 1: at least one press event is pending.
- `key_code`, output, 4: lowest-index pending press. Meaningful only while `key_valid` = 1.
- `key_ready`, input, 1: consumer accepts `key_code`.

## Operation

- **Reset values:** `scan_col` = 0, `col_n` = 4'b1110, phase counter = 0, synchronizer flops = 4'b1111, `key_state` = 0, all debounce counters = 0, pending mask = 0, `key_valid` = 0, `key_code` = 0.
- **Row synchronizer:** two flops on `row_n`. The sampled value is the inverted output of the second flop.
- **Column phase counter:** counts 0..SETTLE_CYCLES.
  - Phase SETTLE_CYCLES is the sample cycle. On that cycle's edge the four keys of `scan_col` are evaluated, then `scan_col` increments, wrapping 3 → 0, and the counter returns to 0.
  - `col_n` is `~(1 << scan_col)`, registered with `scan_col`.
- **Debounce, per key, at its sample edge only:**
  - Sample equals `key_state[k]`: counter set to 0.
  - Sample differs and counter equals DEBOUNCE_SCANS-1: `key_state[k]` toggles and the counter is set to 0.
  - Sample differs otherwise: counter increments.
- **Press events:** a 0→1 toggle of `key_state[k]` sets `pending[k]`. Releases generate no event.
- **Output handshake:**
  - `key_valid` = |pending. `key_code` = index of the lowest set bit of pending. Both are combinational from the pending register.
  - When `key_valid` and `key_ready` are both 1, the bit at `key_code` clears on that edge.
  - `key_code` is stable while `key_valid` = 1 and `key_ready` = 0, unless a lower-index press arrives. The lower index then pre-empts, which is allowed; nothing is lost.
  - If the same bit is set and cleared on the same edge, the set wins.
  - Events for different keys accumulate without loss. A repeat press of a key whose bit is still pending merges into one event.
- **Reset mid-operation:** all state clears immediately, including pending events and debounced levels. After reset the scan restarts at column 0.

## Timing

- Column period is SETTLE_CYCLES+1 cycles. A frame is 4·(SETTLE_CYCLES+1) cycles, which is 16 with the defaults.
- Press latency, from a stable level at `row_n` to `key_state`/`key_valid` rising: DEBOUNCE_SCANS frames plus at most 1 frame plus 2 synchronizer cycles. With the defaults this is at most 82 cycles.
- A bounce shorter than DEBOUNCE_SCANS consecutive frame samples produces no change.
- Acceptance takes effect on the accepting edge. The next pending code appears in the following cycle.

## Structure

- **Shared package `scan_pkg`:**
  - `NUM_COLS` = 4, `NUM_ROWS` = 4, `NUM_KEYS` = 16.
  - `COL_W` = 2, `KEY_W` = 4.
  - `key_idx(col, row)` function returning col·4 + row.
- **Sub-module `key_debounce`:** one instance per key. Ports: clock, reset, `sample_en`, `sample`, `state`, `press_pulse`.
- **Top level:** phase counter, column driver, synchronizer, pending mask and lowest-set-bit priority encoder.

## Test plan

1. **Reset and column walk:** hold `rst_n` = 0, check every output at its reset value. Release reset and check that `col_n` steps 1110 → 1101 → 1011 → 0111 → 1110 every 4 cycles.
2. **Clean press on key 6:** hold `row_n[2]` low only while `col_n[1]` = 0, starting at frame start. Require `key_state[6]` = 1, `key_valid` = 1 and `key_code` = 6 within 82 cycles. Pulse `key_ready` for one cycle; `key_valid` must drop next cycle while `key_state[6]` stays 1.
3. **Bounce rejection:** press key 0 for 3 frames, release for 1 frame, and repeat twice. Require `key_state[0]` = 0 and `key_valid` = 0 throughout.
4. **Multiple pending events:** press keys 9 and 3 together with `key_ready` = 0. Require `key_code` = 3 with `key_valid` = 1. Accept once: `key_code` becomes 9. Accept again: `key_valid` = 0.
5. **Release generates no event:** release key 6 after it was accepted. Require `key_state[6]` to fall after the debounce latency and `key_valid` to stay 0.
6. **Reset mid-operation:** with keys 3 and 9 pending and a debounce in progress on key 12, assert `rst_n` asynchronously. All outputs must clear within the same cycle, and after release the scan must restart at column 0.
